// File: rtl/fpu_issue_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_issue_scheduler: single-issue FPU dispatch with writeback-port        |
// | reservation and a busy tracker for the shared div/sqrt unit.             |
// | Optional: FPU_SCHED_STATS_EN adds stall_cnt / issue_cnt counters.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fpu_issue_scheduler #(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 10,
    parameter int LAT_MISC = 1,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    output logic             start_add,
    output logic             sub_sel,
    output logic             start_mul,
    output logic             start_div,
    output logic             sqrt_sel,
    output logic             start_misc,
    output logic [1:0]       misc_sel,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic             div_busy
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      issue_cnt
`endif
);

    localparam logic [2:0] c_OP_FADD   = 3'd0;
    localparam logic [2:0] c_OP_FSUB   = 3'd1;
    localparam logic [2:0] c_OP_FMUL   = 3'd2;
    localparam logic [2:0] c_OP_FDIV   = 3'd3;
    localparam logic [2:0] c_OP_FSQRT  = 3'd4;
    localparam logic [2:0] c_OP_FFLOOR = 3'd5;
    localparam int         c_DEPTH     = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } div_state_t;

    // r_res[k]: writeback port already claimed k cycles from now (bit 0 = this cycle)
    logic [c_DEPTH-1:0] r_res;
    logic [c_DEPTH-1:0] w_res_next;
    logic [TAG_W-1:0]   r_tag      [c_DEPTH];
    logic [TAG_W-1:0]   w_tag_next [c_DEPTH];
    logic [15:0]        w_res_view;
    logic [3:0]         w_lat;
    logic [3:0]         w_slot;
    logic [2:0]         w_misc_diff;
    logic               w_is_add;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_misc;
    logic               w_accept;
    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;

    always_comb begin
        w_is_add  = (issue_op == c_OP_FADD) || (issue_op == c_OP_FSUB);
        w_is_mul  = (issue_op == c_OP_FMUL);
        w_is_div  = (issue_op == c_OP_FDIV) || (issue_op == c_OP_FSQRT);
        w_is_misc = (issue_op >= c_OP_FFLOOR);
        w_lat     = 4'(LAT_MISC);
        if (w_is_add) begin
            w_lat = 4'(LAT_ADD);
        end else if (w_is_mul) begin
            w_lat = 4'(LAT_MUL);
        end else if (w_is_div) begin
            w_lat = 4'(LAT_DIV);
        end
    end

    assign w_res_view  = {1'b0, r_res};
    assign issue_ready = !rst && !flush && !w_res_view[w_lat] && !(w_is_div && div_busy);
    assign w_accept    = issue_valid && issue_ready;
    assign w_slot      = w_lat - 4'd1;
    assign w_misc_diff = issue_op - c_OP_FFLOOR;

    assign start_add  = w_accept && w_is_add;
    assign sub_sel    = start_add && (issue_op == c_OP_FSUB);
    assign start_mul  = w_accept && w_is_mul;
    assign start_div  = w_accept && w_is_div;
    assign sqrt_sel   = start_div && (issue_op == c_OP_FSQRT);
    assign start_misc = w_accept && w_is_misc;
    assign misc_sel   = start_misc ? w_misc_diff[1:0] : 2'd0;

    // A flushed op's result may still be in slot 0; suppress it in the flush cycle itself
    assign wb_valid = r_res[0] && !rst && !flush;
    assign wb_tag   = wb_valid ? r_tag[0] : '0;

    always_comb begin
        w_res_next = r_res >> 1;
        for (int k = 0; k < c_DEPTH - 1; k++) begin
            w_tag_next[k] = r_tag[k+1];
        end
        w_tag_next[c_DEPTH-1] = '0;
        if (w_accept) begin
            w_res_next[w_slot] = 1'b1;
            w_tag_next[w_slot] = issue_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_res <= '0;
            for (int k = 0; k < c_DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_res <= w_res_next;
            for (int k = 0; k < c_DEPTH; k++) begin
                r_tag[k] <= w_tag_next[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Leave BUSY as the counter reaches zero so a new div issues at t+LAT_DIV
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_div) begin
                    w_cnt_next = 4'(LAT_DIV - 1);
                    if (LAT_DIV > 1) begin
                        w_state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign div_busy = (r_state == ST_BUSY);

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_issue_cnt <= 32'd0;
        end else begin
            if (issue_valid && !issue_ready && !flush) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/fpu_issue_scheduler.md
Name: fpu_issue_scheduler

Overview:
- Issue controller for the FPU cluster: fadd/fsub, fmul, fdiv, fsqrt, ffloor, ftoi, itof.
- Accepts one FP op per cycle from decode and pulses the matching unit's start strobe.
- Reserves the single shared FP register-file writeback port at the op's fixed latency, so no two results ever collide.
- Tracks the non-pipelined fdiv/fsqrt unit with a busy state machine.

Parameters:
- LAT_ADD, 2, fadd/fsub latency in cycles, 1..15
- LAT_MUL, 2, fmul latency
- LAT_DIV, 10, fdiv/fsqrt latency; shared unit, not pipelined
- LAT_MISC, 1, ffloor/ftoi/itof latency
- TAG_W, 6, destination tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all in-flight ops
- issue_valid  in  1  op offered
- issue_op  in  3  0 FADD, 1 FSUB, 2 FMUL, 3 FDIV, 4 FSQRT, 5 FFLOOR, 6 FTOI, 7 ITOF
- issue_tag  in  TAG_W  destination register tag
- issue_ready  out  1  op accepted this cycle if issue_valid
- start_add  out  1  fadd unit start
- sub_sel  out  1  subtract select, valid with start_add
- start_mul  out  1  fmul unit start
- start_div  out  1  div/sqrt unit start
- sqrt_sel  out  1  sqrt select, valid with start_div
- start_misc  out  1  misc unit start
- misc_sel  out  2  0 ffloor, 1 ftoi, 2 itof; valid with start_misc
- wb_valid  out  1  result lands on writeback port this cycle
- wb_tag  out  TAG_W  tag of the landing result
- div_busy  out  1  div/sqrt unit occupied

Behaviour:
- Reset values: all outputs 0, except issue_ready, which is combinational and may be 1 once out of reset. Reservation vector, tag pipeline and div FSM all cleared.
- Accept: issue_valid & issue_ready in cycle t, with L = latency of the op class.
  - The start strobe and its select are asserted combinationally in cycle t.
  - wb_valid=1 with wb_tag=issue_tag exactly in cycle t+L.
- Reservation vector res[1..15]: res[k]=1 means the writeback port is taken k cycles from now.
  - Shifts down one position per cycle.
  - On accept, bit L is set.
- issue_ready = !rst & !flush & !res_next_cycle_view[L] & !(div class & div_busy).
  - Conflict check covers both earlier reservations and the shift occurring this cycle.
  - Depends on issue_op; must not depend on issue_valid.
- Writeback is never stalled; the downstream register file always accepts.
- Div FSM:
  - States IDLE and BUSY, with a 4-bit down-counter.
  - IDLE -> BUSY on div-class accept; counter = LAT_DIV-1.
  - BUSY decrements each cycle; at 0 it returns to IDLE.
  - div_busy = (state==BUSY).
  - Occupancy: accept at t gives div_busy=1 in cycles t+1..t+LAT_DIV-1. A next div/sqrt can be accepted at t+LAT_DIV, the same cycle as the first one's writeback.
- Tag pipeline: per-slot tag registers shift in step with res; wb_tag = slot-0 tag. wb_tag is don't-care when wb_valid=0; hold 0 in the bench-visible model.
- Priority of simultaneous events: rst > flush > normal.
- Flush (also applies to rst):
  - Clears res, the tag pipeline and the div FSM at the next edge.
  - wb_valid=0 from the flush cycle onward for all ops issued before the flush.
  - No accept in the flush cycle.
  - Units are not told; their outputs are simply never written back.
- A different-latency op can issue every cycle as long as its slot is free.
  - Example: FMUL at t (wb t+2), then FFLOOR at t+1 (wb t+2) conflicts and is stalled one cycle.

Optional Feature:
- FPU_SCHED_STATS_EN defined:
  - Adds outputs stall_cnt[31:0] and issue_cnt[31:0].
  - stall_cnt increments each cycle with issue_valid & !issue_ready & !flush.
  - issue_cnt increments on each accept.
  - Both clear on rst only (not flush) and wrap at 2^32.
- Undefined: the counters and ports are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high 3 cycles, issue_valid=1 -> no start, wb_valid=0, issue_ready=0 throughout; first accept in the cycle after rst falls.
- Back-to-back FADD tag 1,2,3 at t, t+1, t+2 -> issue_ready=1 each cycle; wb_valid in t+2, t+3, t+4 with tags 1,2,3; sub_sel=0.
- Slot conflict: FMUL tag 5 at t, FFLOOR tag 6 offered at t+1 -> issue_ready=0 at t+1, accepted at t+2; wb tag 5 at t+2, tag 6 at t+3.
- Div occupancy: FDIV tag 9 at t, FSQRT tag 10 offered from t+1 -> issue_ready=0 for t+1..t+9, accepted at t+10 with sqrt_sel=1; wb tag 9 at t+10, tag 10 at t+20; an FADD at t+8 (wb t+10) must stall one cycle.
- Flush: FDIV at t, FADD at t+1, flush at t+2 -> no wb_valid afterward; div_busy=0 at t+3; FDIV accepted at t+3.
- Randomised 10k ops with random issue_valid and flush, checked against a reference model -> never two results in one wb cycle; every accepted, unflushed op written back exactly once at its latency with the correct tag.
